// File: rtl/apb_controller_fsm.sv
// APB master sequencer for the AHB-to-APB bridge: takes one decoded AHB transfer at a time
// and plays it out as APB SETUP/ENABLE phases, stalling AHB through Hreadyout.
module apb_controller_fsm #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NSEL   = 3
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              valid,
  input  logic              Hwrite,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [NSEL-1:0]   tempselx,
  input  logic [DATA_W-1:0] Prdata,
  output logic [NSEL-1:0]   Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout,
  output logic [DATA_W-1:0] Hrdata
);

  typedef enum logic [2:0] {
    StIdle,
    StRSetup,
    StREnable,
    StRDone,
    StWWait,
    StWSetup,
    StWEnable
  } state_e;

  state_e state_q, state_d;

  // Transfer captured at accept time; write data arrives one cycle later (AHB data phase).
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NSEL-1:0]   sel_q, sel_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [NSEL-1:0]   pselx_q, pselx_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              hready_q, hready_d;

  logic accept;

  // Next-state and transfer capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    write_d = write_q;
    wdata_d = wdata_q;
    accept  = 1'b0;

    unique case (state_q)
      StIdle, StRDone: begin
        accept = valid && (tempselx != '0);
        if (accept) begin
          addr_d  = Haddr;
          sel_d   = tempselx;
          write_d = Hwrite;
          state_d = Hwrite ? StWWait : StRSetup;
        end else begin
          state_d = StIdle;
        end
      end
      StRSetup:  state_d = StREnable;
      StREnable: state_d = StRDone;
      StWWait: begin
        wdata_d = Hwdata;
        state_d = StWSetup;
      end
      StWSetup:  state_d = StWEnable;
      StWEnable: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they are pure Moore outputs
  // with no combinational path from the inputs. Paddr/Pwdata/Pwrite hold unless re-driven.
  always_comb begin
    pselx_d   = '0;
    penable_d = 1'b0;
    hready_d  = 1'b1;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;

    unique case (state_d)
      StRSetup: begin
        pselx_d  = sel_d;
        paddr_d  = addr_d;
        pwrite_d = 1'b0;
        hready_d = 1'b0;
      end
      StREnable: begin
        pselx_d   = pselx_q;
        penable_d = 1'b1;
        hready_d  = 1'b0;
      end
      StWWait: begin
        hready_d = 1'b0;
      end
      StWSetup: begin
        pselx_d  = sel_d;
        paddr_d  = addr_d;
        pwdata_d = wdata_d;
        pwrite_d = 1'b1;
        hready_d = 1'b0;
      end
      StWEnable: begin
        pselx_d   = pselx_q;
        penable_d = 1'b1;
        hready_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      sel_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      pselx_q   <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      hready_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      pselx_q   <= pselx_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      hready_q  <= hready_d;
    end
  end

  assign Pselx     = pselx_q;
  assign Penable   = penable_q;
  assign Pwrite    = pwrite_q;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign Hreadyout = hready_q;
  assign Hrdata    = (state_q == StRDone) ? Prdata : '0;

endmodule

// File: tb/tb_apb_controller_fsm.sv
// Bench for apb_controller_fsm: a per-transfer timeline model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with sporadic resets.
module tb_apb_controller_fsm;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 3;

  logic          Hclk = 1'b0;
  logic          Hreset = 1'b1;
  logic          valid = 1'b0;
  logic          Hwrite = 1'b0;
  logic [AW-1:0] Haddr = '0;
  logic [DW-1:0] Hwdata = '0;
  logic [NS-1:0] tempselx = '0;
  logic [DW-1:0] Prdata = '0;
  logic [NS-1:0] Pselx;
  logic          Penable;
  logic          Pwrite;
  logic [AW-1:0] Paddr;
  logic [DW-1:0] Pwdata;
  logic          Hreadyout;
  logic [DW-1:0] Hrdata;

  int checks = 0;
  int errors = 0;

  always #5 Hclk = ~Hclk;

  apb_controller_fsm #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .NSEL  (NS)
  ) dut (
    .Hclk     (Hclk),
    .Hreset   (Hreset),
    .valid    (valid),
    .Hwrite   (Hwrite),
    .Haddr    (Haddr),
    .Hwdata   (Hwdata),
    .tempselx (tempselx),
    .Prdata   (Prdata),
    .Pselx    (Pselx),
    .Penable  (Penable),
    .Pwrite   (Pwrite),
    .Paddr    (Paddr),
    .Pwdata   (Pwdata),
    .Hreadyout(Hreadyout),
    .Hrdata   (Hrdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted transfer is a fixed timeline counted in cycles since the accept edge.
  // Read : +1 setup, +2 enable, +3 done (ready, Hrdata valid, may accept again)
  // Write: +1 wait (Hwdata sampled), +2 setup, +3 enable, +4 idle
  logic [NS-1:0] m_sel = '0;
  logic          m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  int            ph = 0;
  logic [NS-1:0] e_psel = '0;
  logic          e_pen = 1'b0;
  logic          e_pwrite = 1'b0;
  logic [AW-1:0] e_paddr = '0;
  logic [DW-1:0] e_pwdata = '0;
  logic          e_hready = 1'b1;
  logic          e_rdone = 1'b0;

  task automatic model_step();
    if (Hreset) begin
      ph = 0; e_psel = '0; e_pen = 1'b0; e_pwrite = 1'b0; e_paddr = '0; e_pwdata = '0;
      e_hready = 1'b1; e_rdone = 1'b0;
      return;
    end
    if (e_hready) begin
      if (valid && tempselx != '0) begin
        m_sel = tempselx; m_wr = Hwrite; m_addr = Haddr; ph = 1;
      end else begin
        ph = 0;
      end
    end else begin
      if (m_wr && ph == 1) m_wdata = Hwdata;
      ph++;
      if (m_wr && ph == 4) ph = 0;
    end
    e_pen = 1'b0;
    e_rdone = 1'b0;
    if (ph == 0) begin
      e_psel = '0; e_hready = 1'b1;
    end else if (!m_wr) begin
      if (ph == 1) begin
        e_psel = m_sel; e_paddr = m_addr; e_pwrite = 1'b0; e_hready = 1'b0;
      end else if (ph == 2) begin
        e_pen = 1'b1;
      end else begin
        e_psel = '0; e_hready = 1'b1; e_rdone = 1'b1;
      end
    end else begin
      if (ph == 1) begin
        e_psel = '0; e_hready = 1'b0;
      end else if (ph == 2) begin
        e_psel = m_sel; e_paddr = m_addr; e_pwdata = m_wdata; e_pwrite = 1'b1;
      end else begin
        e_pen = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge Hclk);
    model_step();
  end

  // Every-cycle comparison, plus the ENABLE-follows-identical-SETUP property.
  logic [NS-1:0] pv_psel = '0;
  logic          pv_pen = 1'b0;
  logic          pv_pwrite = 1'b0;
  logic [AW-1:0] pv_paddr = '0;
  logic [DW-1:0] pv_pwdata = '0;

  initial forever begin
    @(posedge Hclk);
    #1;
    chk("Pselx", 32'(Pselx), 32'(e_psel));
    chk("Penable", 32'(Penable), 32'(e_pen));
    chk("Pwrite", 32'(Pwrite), 32'(e_pwrite));
    chk("Paddr", Paddr, e_paddr);
    chk("Pwdata", Pwdata, e_pwdata);
    chk("Hreadyout", 32'(Hreadyout), 32'(e_hready));
    chk("Hrdata", Hrdata, e_rdone ? Prdata : 32'h0);
    if (Penable === 1'b1) begin
      chk("enable_after_setup", 32'(pv_psel != '0 && !pv_pen && pv_psel == Pselx &&
          pv_paddr == Paddr && pv_pwrite == Pwrite && pv_pwdata == Pwdata), 32'd1);
    end
    pv_psel = Pselx; pv_pen = Penable; pv_pwrite = Pwrite; pv_paddr = Paddr;
    pv_pwdata = Pwdata;
  end

  task automatic step();
    @(negedge Hclk);
  endtask

  task automatic req(input logic wr, input logic [AW-1:0] a, input logic [NS-1:0] s);
    valid = 1'b1; Hwrite = wr; Haddr = a; tempselx = s;
  endtask

  initial begin
    int low;
    Prdata = 32'h5A;
    step(); step();
    Hreset = 1'b0;
    chk("rst_psel", 32'(Pselx), 0);
    chk("rst_hready", 32'(Hreadyout), 1);
    chk("rst_paddr", Paddr, 0);
    chk("rst_hrdata", Hrdata, 0);

    // Single read
    req(1'b0, 32'h8000_0010, 3'b001);
    step(); valid = 1'b0;
    chk("rd_setup_psel", 32'(Pselx), 1);
    chk("rd_setup_pen", 32'(Penable), 0);
    chk("rd_setup_paddr", Paddr, 32'h8000_0010);
    step();
    chk("rd_enable_pen", 32'(Penable), 1);
    step();
    chk("rd_done_hready", 32'(Hreadyout), 1);
    chk("rd_done_hrdata", Hrdata, 32'h5A);
    step();
    chk("rd_idle_hrdata", Hrdata, 0);

    // Single write: Hreadyout low for exactly 3 cycles
    req(1'b1, 32'h8400_0020, 3'b010);
    step(); valid = 1'b0; Hwdata = 32'hDEAD_BEEF;
    chk("wr_wait_psel", 32'(Pselx), 0);
    low = 1;
    step(); Hwdata = 32'h0;
    chk("wr_setup_psel", 32'(Pselx), 2);
    chk("wr_setup_pwrite", 32'(Pwrite), 1);
    chk("wr_setup_pwdata", Pwdata, 32'hDEAD_BEEF);
    chk("wr_setup_paddr", Paddr, 32'h8400_0020);
    for (int i = 0; i < 8 && !Hreadyout; i++) begin
      low++;
      step();
    end
    chk("wr_stall_cycles", 32'(low), 3);

    // Back-to-back reads, second request held through the transfer
    step();
    req(1'b0, 32'h8000_0000, 3'b001);
    step(); Haddr = 32'h8000_0004;
    chk("b2b_paddr0", Paddr, 32'h8000_0000);
    step();
    chk("b2b_paddr_held", Paddr, 32'h8000_0000);
    step();
    chk("b2b_done", 32'(Hreadyout), 1);
    step(); valid = 1'b0;
    chk("b2b_setup2_psel", 32'(Pselx), 1);
    chk("b2b_paddr1", Paddr, 32'h8000_0004);
    step(); step(); step();

    // Ignored requests
    req(1'b0, 32'h8000_0200, 3'b000);
    step(); valid = 1'b0;
    chk("nosel_psel", 32'(Pselx), 0);
    chk("nosel_hready", 32'(Hreadyout), 1);
    req(1'b0, 32'h8000_0100, 3'b001);
    step(); valid = 1'b0;
    step(); req(1'b1, 32'hFFFF_0000, 3'b100);
    step(); valid = 1'b0;
    chk("pulse_paddr", Paddr, 32'h8000_0100);
    step();
    chk("pulse_idle_psel", 32'(Pselx), 0);
    chk("pulse_idle_hready", 32'(Hreadyout), 1);

    // Write then read of the same address
    req(1'b1, 32'h8800_0000, 3'b100);
    step(); valid = 1'b0; Hwdata = 32'h1234_5678;
    step(); Hwdata = 32'h0;
    chk("wr2_pwrite", 32'(Pwrite), 1);
    step(); step();
    req(1'b0, 32'h8800_0000, 3'b100);
    step(); valid = 1'b0;
    chk("rd2_pwrite", 32'(Pwrite), 0);
    chk("rd2_pwdata_held", Pwdata, 32'h1234_5678);
    step(); step(); step();

    // Reset during write SETUP
    req(1'b1, 32'h8C00_0040, 3'b010);
    step(); valid = 1'b0; Hwdata = 32'hA5A5_A5A5;
    step();
    chk("rst_mid_psel_before", 32'(Pselx), 2);
    Hreset = 1'b1;
    step();
    chk("rst_mid_psel", 32'(Pselx), 0);
    chk("rst_mid_paddr", Paddr, 0);
    chk("rst_mid_pwdata", Pwdata, 0);
    chk("rst_mid_hready", 32'(Hreadyout), 1);
    step(); Hreset = 1'b0;
    step();
    chk("rst_mid_no_pen", 32'(Penable), 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step();
      Hreset = ($urandom_range(0, 99) == 0);
      valid = ($urandom_range(0, 9) < 7);
      Hwrite = $urandom_range(0, 1);
      Haddr = $urandom;
      Hwdata = $urandom;
      Prdata = $urandom_range(0, 255);
      case ($urandom_range(0, 3))
        0: tempselx = 3'b000;
        1: tempselx = 3'b001;
        2: tempselx = 3'b010;
        default: tempselx = 3'b100;
      endcase
    end
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
